data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares one `data_memory` instance (write at clock edge, combinational read) between two requesters: m0 (CPU load/store port) and m1 (DMA/debug port).
- Round-robin arbitration; each access runs through a 3-state sequencer.
- Drives the memory's `WE`/`A`/`WD`; registers `RD` back to the granted requester.
- Flags out-of-range addresses without touching memory.

Parameters:
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 32, byte-address width
MEM_SIZE, 256, memory depth in words; legal byte addresses 0 .. 4*MEM_SIZE-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
m0_req  in  1  m0 access request, held until m0_ack
m0_we  in  1  m0 write enable (1 = write, 0 = read), stable while m0_req
m0_addr  in  ADDR_WIDTH  m0 byte address, stable while m0_req
m0_wdata  in  DATA_WIDTH  m0 write data, stable while m0_req
m0_ack  out  1  one-cycle completion pulse for m0
m0_err  out  1  valid with m0_ack; 1 = address out of range
m0_rdata  out  DATA_WIDTH  read data, valid with m0_ack on reads
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata  same as m0 for requester 1
mem_we  out  1  to memory WE
mem_addr  out  ADDR_WIDTH  to memory A, bits [1:0] forced to 0
mem_wdata  out  DATA_WIDTH  to memory WD
mem_rdata  in  DATA_WIDTH  from memory RD (combinational)
busy  out  1  1 whenever state != IDLE

Behaviour:
Reset (reset=0, asynchronous):
- state=IDLE; rr_last=1, so m0 wins the first tie.
- All ack/err/we outputs 0; all data/address outputs 0.
- Assertion mid-access aborts the access immediately: no ack is issued and mem_we drops at once. A write whose edge has not occurred is not performed.

States:
- IDLE:
  - If no req: stay.
  - If one req: grant it.
  - If both: grant the requester != rr_last.
  - At the edge: latch gnt, we, addr, wdata; set rr_last=gnt; go to ACCESS.
  - Range check computed on the latched addr: err = (addr >> 2) >= MEM_SIZE.
- ACCESS (exactly 1 cycle):
  - mem_addr = latched addr with [1:0]=0; mem_wdata = latched wdata.
  - mem_we = latched we AND NOT err. Memory writes at the edge leaving ACCESS.
  - At that edge, rdata_reg <= mem_rdata on a read with no err; otherwise rdata_reg <= 0.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - Granted requester sees ack=1, err per range check, rdata=rdata_reg.
  - Non-granted ack=0. mem_we=0.
  - Go to IDLE.

Outside ACCESS: mem_we=0; mem_addr/mem_wdata hold their last value.

Timing and throughput:
- Latency: req seen high in IDLE at cycle 0 -> ack high in cycle 2.
- Throughput: one access per 3 cycles.

Requester protocol:
- Keep req, we, addr and wdata stable from assertion until the ack cycle.
- Any req=1 sampled in IDLE (including the cycle after ack) is a new request.

Other rules:
- A req arriving while busy waits; no queueing beyond the held req.
- The loser of a tie is served next, because rr_last alternates. Neither requester starves with both continuously requesting: grants go 0,1,0,1...
- rdata outputs: m0_rdata and m1_rdata both carry rdata_reg. They are meaningful only with their own ack.
- Unaligned addresses (e.g. 0x13) access word 0x10; err is based on the word index.

Test Plan:
- Reset low 2 cycles then high; m0 writes 0xCAFEBABE to 0x10 -> mem_we=1 only in ACCESS with mem_addr=0x10; m0_ack=1, m0_err=0 in cycle 2; subsequent m0 read of 0x10 -> m0_rdata=0xCAFEBABE.
- m1 writes 0xDEADBEEF to 0x13, then m1 reads 0x10 -> mem_addr=0x10 during the write; read returns 0xDEADBEEF.
- m0 and m1 assert req in the same cycle after reset, both holding continuously -> grant order m0, m1, m0, m1; exactly one ack per 3 cycles; never both acks high.
- m0 writes to 0x400 (word 256, MEM_SIZE=256) -> mem_we stays 0; m0_ack=1 with m0_err=1; read of 0x400 -> m0_rdata=0, m0_err=1.
- m1 write of 0x12345678 to 0x20; drive reset=0 during ACCESS before the edge -> mem_we falls immediately; no m1_ack; busy=0. After release, m1 read of 0x20 does not return 0x12345678.
- m0 holds req across the ack cycle while m1 idle -> second m0 access starts in the IDLE cycle after ack; back-to-back acks spaced 3 cycles.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one word-addressed data memory between two
// requesters; each access is sequenced IDLE -> ACCESS -> RESP.
module data_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  function automatic logic addr_out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> 2) >= ADDR_WIDTH'(MEM_SIZE);
  endfunction

  logic [1:0]            state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  rr_last_q, rr_last_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic                  m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic                  busy_q, busy_d;

  logic                  sel_m1_s;
  logic                  req_we_s;
  logic [ADDR_WIDTH-1:0] req_addr_s;
  logic [DATA_WIDTH-1:0] req_wdata_s;
  logic                  req_err_s;

  // On a tie the requester that was not granted last time wins.
  assign sel_m1_s    = m1_req & (~m0_req | ~rr_last_q);
  assign req_we_s    = sel_m1_s ? m1_we    : m0_we;
  assign req_addr_s  = sel_m1_s ? m1_addr  : m0_addr;
  assign req_wdata_s = sel_m1_s ? m1_wdata : m0_wdata;
  assign req_err_s   = addr_out_of_range(req_addr_s);

  // Sequencer next-state and output computation.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_last_d   = rr_last_q;
    we_d        = we_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m0_err_d    = 1'b0;
    m1_err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          state_d     = S_ACCESS;
          gnt_d       = sel_m1_s;
          rr_last_d   = sel_m1_s;
          we_d        = req_we_s;
          err_d       = req_err_s;
          mem_we_d    = req_we_s & ~req_err_s;
          mem_addr_d  = {req_addr_s[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata_d = req_wdata_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        state_d  = S_RESP;
        rdata_d  = (!we_q && !err_q) ? mem_rdata : {DATA_WIDTH{1'b0}};
        m0_ack_d = ~gnt_q;
        m1_ack_d = gnt_q;
        m0_err_d = ~gnt_q & err_q;
        m1_err_d = gnt_q & err_q;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset also kills an in-flight write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      gnt_q       <= 1'b0;
      rr_last_q   <= 1'b1;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q <= {DATA_WIDTH{1'b0}};
      rdata_q     <= {DATA_WIDTH{1'b0}};
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_last_q   <= rr_last_d;
      we_q        <= we_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      m0_err_q    <= m0_err_d;
      m1_err_q    <= m1_err_d;
      busy_q      <= busy_d;
    end
  end

  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural data_memory model
// (synchronous write, combinational read).
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;
  logic        mem_clear;

  logic [31:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // One complete access starting in IDLE; checks every cycle of the sequence.
  task automatic run_txn(input string tag, input logic m, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_we, input logic [31:0] exp_maddr,
                         input logic exp_err, input logic [31:0] exp_rdata);
    if (m) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
    @(negedge clk);
    check({tag, ":idle_busy"}, 32'(busy), 32'd0);
    check({tag, ":idle_we"}, 32'(mem_we), 32'd0);
    @(negedge clk);
    check({tag, ":acc_we"}, 32'(mem_we), 32'(exp_we));
    check({tag, ":acc_addr"}, mem_addr, exp_maddr);
    check({tag, ":acc_acks"}, 32'({m1_ack, m0_ack}), 32'd0);
    check({tag, ":acc_busy"}, 32'(busy), 32'd1);
    if (exp_we) check({tag, ":acc_wdata"}, mem_wdata, wdata);
    @(negedge clk);
    check({tag, ":resp_acks"}, 32'({m1_ack, m0_ack}), m ? 32'd2 : 32'd1);
    check({tag, ":resp_err"}, 32'(m ? m1_err : m0_err), 32'(exp_err));
    check({tag, ":resp_rdata"}, m ? m1_rdata : m0_rdata, exp_rdata);
    check({tag, ":resp_we"}, 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  logic [1:0] tie_exp  [12];
  logic [1:0] hold_exp [6];

  initial begin
    tie_exp  = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2};
    hold_exp = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
    reset = 1'b0; mem_clear = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;

    @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_acks", 32'({m1_ack, m0_ack}), 32'd0);
    check("rst_errs", 32'({m1_err, m0_err}), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rdata", m0_rdata, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1; mem_clear = 1'b0;

    run_txn("m0_wr10", 1'b0, 1'b1, 32'h10, 32'hCAFEBABE, 1'b1, 32'h10, 1'b0, 32'd0);
    run_txn("m0_rd10", 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 32'h10, 1'b0, 32'hCAFEBABE);
    run_txn("m1_wr13", 1'b1, 1'b1, 32'h13, 32'hDEADBEEF, 1'b1, 32'h10, 1'b0, 32'd0);
    run_txn("m1_rd10", 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 32'h10, 1'b0, 32'hDEADBEEF);
    run_txn("m0_wr3fc", 1'b0, 1'b1, 32'h3FC, 32'h000055AA, 1'b1, 32'h3FC, 1'b0, 32'd0);
    run_txn("m0_rd3fc", 1'b0, 1'b0, 32'h3FC, 32'd0, 1'b0, 32'h3FC, 1'b0, 32'h000055AA);
    run_txn("m0_wr400", 1'b0, 1'b1, 32'h400, 32'h11112222, 1'b0, 32'h400, 1'b1, 32'd0);
    run_txn("m0_rd400", 1'b0, 1'b0, 32'h400, 32'd0, 1'b0, 32'h400, 1'b1, 32'd0);
    run_txn("m0_rd000", 1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0, 1'b0, 32'd0);

    // Reset asserted while a write is in ACCESS.
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    check("abort_pre_we", 32'(mem_we), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("abort_acks", 32'({m1_ack, m0_ack}), 32'd0);
    m1_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    run_txn("m1_rd20", 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 32'h20, 1'b0, 32'd0);

    // Both requesting continuously from reset: strict alternation.
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h3FC;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("tie_acks_c%0d", k), 32'({m1_ack, m0_ack}), 32'(tie_exp[k]));
      if (tie_exp[k] == 2'd1) check($sformatf("tie_m0_rdata_c%0d", k), m0_rdata, 32'hDEADBEEF);
      if (tie_exp[k] == 2'd2) check($sformatf("tie_m1_rdata_c%0d", k), m1_rdata, 32'h000055AA);
    end
    @(posedge clk);
    #1 m0_req = 1'b0; m1_req = 1'b0;

    // m0 holds req through its ack: back-to-back accesses.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("hold_acks_c%0d", k), 32'({m1_ack, m0_ack}), 32'(hold_exp[k]));
      if (hold_exp[k] == 2'd1) check($sformatf("hold_rdata_c%0d", k), m0_rdata, 32'hDEADBEEF);
    end
    @(posedge clk);
    #1 m0_req = 1'b0;
    @(negedge clk);
    check("final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
